// File: rtl/fetch_prefetch_buffer.sv
// Fetch front end: sequential imem reads into an in-order {pc,instr} FIFO; redirect flushes and drops in-flight words.
// One cycle response-to-instr_F latency; define PREFETCH_BYPASS_EN for a same-cycle path when the FIFO is empty.
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_D,
  output logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PCplus_4F,
  output logic        instr_valid_F
);

  localparam int          PW         = $clog2(DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [CW:0] L_CREDITS  = DEPTH[CW:0];
  localparam logic [CW-1:0] L_FULL   = DEPTH[CW-1:0];
  localparam logic [31:0] NOP        = 32'h00000013;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];

  logic [CW:0]   w_inflight;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_drop;
  logic          w_rsp_live;
  logic          w_bypass;
  logic          w_bypass_take;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;
  logic [CW-1:0] w_out_after_rsp;
  logic [CW-1:0] w_out_next;
  logic [31:0]   w_head_instr;
  logic [31:0]   w_head_pc;
  logic          w_unused;

  assign w_unused = ^redirect_pc[1:0];

  // Buffered plus outstanding words never exceed DEPTH, so every response has a slot.
  assign w_inflight    = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid   = !rst && !redirect && (w_inflight < L_CREDITS);
  assign w_req_fire    = w_req_valid && imem_req_ready;
  assign w_rsp_drop    = imem_rsp_valid && (r_discard != '0);
  assign w_rsp_live    = imem_rsp_valid && (r_discard == '0) && !redirect;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass      = !rst && w_rsp_live && (r_count == '0);
  assign w_bypass_take = w_bypass && !stall_D;
`else
  assign w_bypass      = 1'b0;
  assign w_bypass_take = 1'b0;
`endif

  assign w_push = w_rsp_live && !w_bypass_take;
  assign w_pop  = (r_count != '0) && !stall_D && !redirect;

  // Requests are blocked during redirect, so this also yields the post-redirect count.
  assign w_out_after_rsp = r_outstanding - CW'(imem_rsp_valid);
  assign w_out_next      = w_out_after_rsp + CW'(w_req_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_count    <= '0;
        r_discard  <= w_out_after_rsp;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_rsp_live) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
        end
        if (w_rsp_drop) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rsp_data;
      r_mem_pc[r_wr_ptr]    <= r_rsp_pc;
    end
  end

  assign w_head_instr = r_mem_instr[r_rd_ptr];
  assign w_head_pc    = r_mem_pc[r_rd_ptr];

  always_comb begin
    instr_valid_F = 1'b0;
    instr_F       = NOP;
    PC_F          = 32'h0;
    PCplus_4F     = 32'h0;
    if (r_count != '0) begin
      instr_valid_F = 1'b1;
      instr_F       = w_head_instr;
      PC_F          = w_head_pc;
      PCplus_4F     = w_head_pc + 32'd4;
    end else if (w_bypass) begin
      instr_valid_F = 1'b1;
      instr_F       = imem_rsp_data;
      PC_F          = r_rsp_pc;
      PCplus_4F     = r_rsp_pc + 32'd4;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && (r_count == L_FULL)));

endmodule
